uart_rx_ctrl: RTL

Sequencing controller for the UART receiver. It drives the receiver's enable and detects end-of-frame from the receiver's busy/error outputs. Good bytes go into a small first-word-fall-through FIFO with a valid/ready consumer handshake. It also provides graceful and forced disable, sticky overrun and a saturating frame-error counter. It sits between the receiver and the byte consumer (host/bus logic).

---
 rtl/uart_rx_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// Sequencing controller for the UART receiver: enable control, end-of-frame detection,
// FWFT byte FIFO with valid/ready drain, sticky overrun and saturating frame-error count.
module uart_rx_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_on,
    input  logic                     abort,
    output logic                     rx_enable,
    input  logic                     rx_busy,
    input  logic                     rx_error,
    input  logic [7:0]               rx_data,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overrun,
    output logic [CNT_W-1:0]         err_count,
    input  logic                     clear_status,
    output logic [1:0]               state_o
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_OFF    = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    localparam logic [AW:0]      FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] ERR_MAX    = '1;

    logic [1:0]    state, next_state;
    logic          busy_q;
    logic          abort_pending;
    logic          frame_end;
    logic          push_req, push_ok, pop, err_inc, overrun_set;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    hold_q;

    assign frame_end = busy_q & ~rx_busy;

    // A frame that ends after an abort is the receiver reporting the cut-off, not real data.
    assign push_req    = frame_end & ~abort_pending & ~rx_error;
    assign err_inc     = frame_end & ~abort_pending &  rx_error;
    assign pop         = out_valid & out_ready;
    assign push_ok     = push_req & ((fifo_count < FULL_COUNT) | pop);
    assign overrun_set = push_req & ~push_ok;

    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : hold_q;
    assign state_o   = state;

    always_comb begin
        // NOTE: default assignment first so every path drives next_state; no latch is inferred.
        next_state = state;
        if (abort) begin
            next_state = S_OFF;
        end else begin
            case (state)
                S_OFF:    if (rx_on)     next_state = S_ARMED;
                S_ARMED:  if (!rx_on)    next_state = S_OFF;
                          else if (rx_busy) next_state = S_ACTIVE;
                S_ACTIVE: if (frame_end) next_state = S_ARMED;
                          else if (!rx_on) next_state = S_DRAIN;
                S_DRAIN:  if (frame_end) next_state = S_OFF;
                          else if (rx_on) next_state = S_ACTIVE;
                default:  next_state = S_OFF;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_OFF;
            rx_enable     <= 1'b0;
            busy_q        <= 1'b0;
            abort_pending <= 1'b0;
        end else begin
            state     <= next_state;
            rx_enable <= (next_state != S_OFF);
            busy_q    <= rx_busy;
            if (abort && rx_busy)
                abort_pending <= 1'b1;
            else if (frame_end || !rx_busy)
                abort_pending <= 1'b0;
        end
    end

    // NOTE: the byte storage has no reset; out_valid gates it and hold_q supplies the idle value.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            hold_q     <= 8'h00;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold_q <= mem[rd_ptr];
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Status events take precedence over a coincident clear so none is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun   <= 1'b0;
            err_count <= '0;
        end else begin
            if (overrun_set)
                overrun <= 1'b1;
            else if (clear_status)
                overrun <= 1'b0;

            if (err_inc) begin
                if (clear_status)
                    err_count <= {{(CNT_W-1){1'b0}}, 1'b1};
                else if (err_count != ERR_MAX)
                    err_count <= err_count + 1'b1;
            end else if (clear_status) begin
                err_count <= '0;
            end
        end
    end

endmodule
